// File: rtl/mmcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// mmcm_lock_supervisor
//
// Brings an MMCM out of reset, waits for LOCKED, filters it for stability,
// and only then releases the reset of the logic that runs on the MMCM output
// clocks. A lock attempt that times out is retried with a fresh MMCM reset
// pulse. After MAX_RETRIES consecutive timeouts the block parks in FAULT with
// the MMCM held in reset until reset or force_reset.
//
// Parameters
//   RST_HOLD_CYCLES  cycles mmcm_reset is held high per attempt (>= 1)
//   LOCK_TIMEOUT     WAIT_LOCK cycles before an attempt counts as failed
//   LOCK_FILTER      consecutive synchronised-lock cycles required for RUN
//   MAX_RETRIES      consecutive timeouts that force FAULT (>= 1)
//
// Ports
//   clk_in        in   free-running MMCM reference clock (only clock)
//   reset         in   synchronous active-high reset
//   mmcm_locked   in   MMCM LOCKED, asynchronous to clk_in
//   force_reset   in   single-cycle request to restart the MMCM
//   mmcm_reset    out  drives MMCM RST
//   sys_reset     out  active-high reset for logic on MMCM output clocks
//   clocks_ok     out  high only in RUN
//   fault         out  high only in FAULT
//   relock_count  out  loss-of-lock events seen in RUN, saturating at 255
//   state_out     out  current state (only with MMCM_SUP_STATE_OUT_EN)
//
// Build option
//   MMCM_SUP_STATE_OUT_EN  when defined, adds the 3-bit state_out port:
//                          RESET_MMCM=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAULT=4.
// -----------------------------------------------------------------------------
module mmcm_lock_supervisor #(
  parameter int RST_HOLD_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 100000,
  parameter int LOCK_FILTER     = 64,
  parameter int MAX_RETRIES     = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       mmcm_locked,
  input  logic       force_reset,
  output logic       mmcm_reset,
  output logic       sys_reset,
  output logic       clocks_ok,
  output logic       fault,
  output logic [7:0] relock_count
`ifdef MMCM_SUP_STATE_OUT_EN
  ,
  output logic [2:0] state_out
`endif
);

  localparam int HOLD_W  = $clog2(RST_HOLD_CYCLES + 1);
  localparam int TMR_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  // Terminal counts: each counter starts at 0 on state entry, so the last
  // cycle of a phase is the one where the counter reads N-1.
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    ST_RESET_MMCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_FILTER     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // LOCKED synchroniser. Nothing downstream looks at mmcm_locked directly.
  // ---------------------------------------------------------------------------
  logic sync_meta_reg;
  logic locked_sync;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_meta_reg <= 1'b0;
      locked_sync   <= 1'b0;
    end else begin
      sync_meta_reg <= mmcm_locked;
      locked_sync   <= sync_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t               state_reg,  state_next;
  logic [HOLD_W-1:0]    hold_reg,   hold_next;
  logic [TMR_W-1:0]     timer_reg,  timer_next;
  logic [FILT_W-1:0]    filt_reg,   filt_next;
  logic [RETRY_W-1:0]   retry_reg,  retry_next;
  logic [7:0]           relock_reg, relock_next;

  logic mmcm_reset_reg, mmcm_reset_next;
  logic sys_reset_reg,  sys_reset_next;
  logic clocks_ok_reg,  clocks_ok_next;
  logic fault_reg,      fault_next;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_reg      <= ST_RESET_MMCM;
      hold_reg       <= '0;
      timer_reg      <= '0;
      filt_reg       <= '0;
      retry_reg      <= '0;
      relock_reg     <= '0;
      mmcm_reset_reg <= 1'b1;
      sys_reset_reg  <= 1'b1;
      clocks_ok_reg  <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      timer_reg      <= timer_next;
      filt_reg       <= filt_next;
      retry_reg      <= retry_next;
      relock_reg     <= relock_next;
      mmcm_reset_reg <= mmcm_reset_next;
      sys_reset_reg  <= sys_reset_next;
      clocks_ok_reg  <= clocks_ok_next;
      fault_reg      <= fault_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    timer_next  = timer_reg;
    filt_next   = filt_reg;
    retry_next  = retry_reg;
    relock_next = relock_reg;

    if (force_reset) begin
      // A restart request beats every transition, including a loss of lock
      // in RUN, so relock_count is deliberately left alone here.
      state_next = ST_RESET_MMCM;
      hold_next  = '0;
      retry_next = '0;
    end else begin
      unique case (state_reg)
        ST_RESET_MMCM: begin
          if (hold_reg == HOLD_LAST) begin
            state_next = ST_WAIT_LOCK;
            timer_next = '0;
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before the timeout so a lock arriving on the
          // timeout cycle still counts.
          if (locked_sync) begin
            state_next = ST_FILTER;
            filt_next  = '0;
          end else if (timer_reg == TMR_LAST) begin
            retry_next = retry_reg + 1'b1;
            if (retry_reg == RETRY_LAST) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_RESET_MMCM;
              hold_next  = '0;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end

        ST_FILTER: begin
          // A glitch sends us back to waiting without a fresh MMCM reset and
          // without charging it against the retry budget.
          if (!locked_sync) begin
            state_next = ST_WAIT_LOCK;
            timer_next = '0;
          end else if (filt_reg == FILT_LAST) begin
            state_next = ST_RUN;
            retry_next = '0;
          end else begin
            filt_next = filt_reg + 1'b1;
          end
        end

        ST_RUN: begin
          retry_next = '0;
          if (!locked_sync) begin
            state_next = ST_RESET_MMCM;
            hold_next  = '0;
            if (relock_reg != 8'hFF) begin
              relock_next = relock_reg + 8'd1;
            end
          end
        end

        ST_FAULT: begin
          state_next = ST_FAULT;
        end

        default: begin
          state_next = ST_RESET_MMCM;
          hold_next  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered together with it,
  // so they change on the same edge as the state and never glitch.
  always_comb begin
    mmcm_reset_next = 1'b1;
    sys_reset_next  = 1'b1;
    clocks_ok_next  = 1'b0;
    fault_next      = 1'b0;
    unique case (state_next)
      ST_RUN: begin
        mmcm_reset_next = 1'b0;
        sys_reset_next  = 1'b0;
        clocks_ok_next  = 1'b1;
      end
      ST_WAIT_LOCK, ST_FILTER: begin
        mmcm_reset_next = 1'b0;
      end
      ST_FAULT: begin
        fault_next = 1'b1;
      end
      default: begin
        mmcm_reset_next = 1'b1;
      end
    endcase
  end

  assign mmcm_reset   = mmcm_reset_reg;
  assign sys_reset    = sys_reset_reg;
  assign clocks_ok    = clocks_ok_reg;
  assign fault        = fault_reg;
  assign relock_count = relock_reg;

`ifdef MMCM_SUP_STATE_OUT_EN
  // state_reg is itself a flop, so this port is registered.
  assign state_out = state_reg;
`endif

endmodule

// File: doc/mmcm_lock_supervisor.md
MMCM_LOCK_SUPERVISOR -- requirements
Module: mmcm_lock_supervisor

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 16: cycles mmcm_reset is held high per reset attempt (minimum 1).
REQ-002 Parameter LOCK_TIMEOUT, default 100000: WAIT_LOCK cycles before an attempt is declared failed (1 ms at 100 MHz).
REQ-003 Parameter LOCK_FILTER, default 64: consecutive synchronised-lock cycles required before RUN.
REQ-004 Parameter MAX_RETRIES, default 8: consecutive timeouts that force FAULT (minimum 1).
REQ-005 clk_in  input  1  free-running MMCM reference clock; the only clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mmcm_locked  input  1  MMCM LOCKED, asynchronous to clk_in.
REQ-008 force_reset  input  1  single-cycle request to restart the MMCM.
REQ-009 mmcm_reset  output  1  drives MMCM RST.
REQ-010 sys_reset  output  1  active-high reset for logic on MMCM output clocks.
REQ-011 clocks_ok  output  1  high only in RUN.
REQ-012 fault  output  1  high only in FAULT.
REQ-013 relock_count  output  8  loss-of-lock events seen in RUN, saturating at 255.

Function
REQ-014 mmcm_locked SHALL pass a 2-flop synchroniser (locked_sync) before any use; all outputs SHALL be registered.
REQ-015 States: RESET_MMCM, WAIT_LOCK, FILTER, RUN, FAULT.
REQ-016 RESET_MMCM: mmcm_reset=1 for exactly RST_HOLD_CYCLES cycles, then WAIT_LOCK with mmcm_reset=0.
REQ-017 WAIT_LOCK: cycle timer starts at 0 on entry; locked_sync=1 -> FILTER; timer reaching LOCK_TIMEOUT -> retry counter +1, then FAULT if it equals MAX_RETRIES, else RESET_MMCM.
REQ-018 FILTER: LOCK_FILTER consecutive locked_sync=1 cycles -> RUN; any locked_sync=0 -> WAIT_LOCK with timer restarted, retry counter unchanged.
REQ-019 RUN: sys_reset=0, clocks_ok=1, retry counter cleared; locked_sync=0 -> RESET_MMCM and relock_count +1 (saturating).
REQ-020 Latency: sys_reset falls exactly 2+LOCK_FILTER+1 cycles after mmcm_locked rises when the lock is stable; sys_reset rises 1 cycle after locked_sync falls in RUN.
REQ-021 FAULT: mmcm_reset=1, sys_reset=1, fault=1, clocks_ok=0; leaves only via reset or force_reset.
REQ-022 sys_reset SHALL be 1 in every state except RUN.
REQ-023 force_reset=1 in any state SHALL enter RESET_MMCM next cycle, restart the hold count, clear the retry counter and fault; relock_count unchanged.
REQ-024 force_reset and loss of lock in the same RUN cycle: force_reset wins; relock_count not incremented.
REQ-025 Timeout and locked_sync=1 in the same WAIT_LOCK cycle: lock wins (-> FILTER).

Reset
REQ-026 reset=1 SHALL, at the next clk_in edge: state=RESET_MMCM, hold count=0, timer=0, retry counter=0, synchroniser=0, mmcm_reset=1, sys_reset=1, clocks_ok=0, fault=0, relock_count=0.
REQ-027 reset in any state mid-operation SHALL override force_reset and all state transitions.
REQ-028 Hold count of RESET_MMCM SHALL begin on the first cycle after reset deasserts.

Configuration
REQ-029 Macro MMCM_SUP_STATE_OUT_EN defined: add output state_out (3 bits) = current state, RESET_MMCM=0, WAIT_LOCK=1, FILTER=2, RUN=3, FAULT=4, registered, reset value 0.
REQ-030 Macro undefined: port state_out absent; all other behaviour identical.

Verification (RST_HOLD_CYCLES=4, LOCK_TIMEOUT=20, LOCK_FILTER=8, MAX_RETRIES=2)
REQ-031 Release reset, raise mmcm_locked 6 cycles later and hold -> mmcm_reset high 4 cycles; sys_reset falls, clocks_ok rises 11 cycles after mmcm_locked rise.
REQ-032 mmcm_locked held 0 -> two attempts of 4+20 cycles each; fault=1, mmcm_reset=1 from cycle 48 on; then force_reset pulse -> fault=0, new 4-cycle hold.
REQ-033 In RUN drop mmcm_locked 300 times -> sys_reset rises 3 cycles after each drop, relock_count saturates at 255.
REQ-034 In FILTER glitch mmcm_locked low 1 cycle after 5 good cycles -> return to WAIT_LOCK, RUN reached only after 8 new consecutive cycles, relock_count=0.
REQ-035 In RUN assert force_reset in the same cycle locked_sync falls -> RESET_MMCM, relock_count unchanged; assert reset mid-FILTER -> all outputs at REQ-026 values next cycle.
REQ-036 With MMCM_SUP_STATE_OUT_EN: state_out walks 0,1,2,3 in REQ-031 and reads 4 in REQ-032.
